// File: rtl/apb_timer8.sv
// 8-bit up/down timer with /1,/2,/4,/8 prescaler, sticky wrap flags and a
// registered level interrupt, behind a zero-wait-state APB slave.
module apb_timer8 #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              interrupt
);

   localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_TIER = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(4);

   logic [DATA_W-1:0] tdr, cnt;
   logic              load, dir, en;
   logic [1:0]        cks;
   logic              ovf, udf, ovf_ie, udf_ie;
   logic [2:0]        presc, presc_top;
   logic              wr, rd, run, tick, cks_chg, ovf_set, udf_set;
   logic              wr_tcr, wr_tsr;

   assign wr      = psel & penable & pwrite;
   assign rd      = psel & penable & ~pwrite;
   assign pready  = psel & penable & ~preset;
   assign wr_tcr  = wr && (paddr == A_TCR);
   assign wr_tsr  = wr && (paddr == A_TSR);
   assign run     = en & ~load;
   assign cks_chg = wr_tcr && (pwdata[1:0] != cks);

   always_comb begin
      presc_top = 3'd0;
      case (cks)
         2'd0: presc_top = 3'd0;
         2'd1: presc_top = 3'd1;
         2'd2: presc_top = 3'd3;
         2'd3: presc_top = 3'd7;
         default: presc_top = 3'd0;
      endcase
   end

   assign tick    = run && (presc == presc_top);
   assign ovf_set = tick && !dir && (cnt == '1);
   assign udf_set = tick &&  dir && (cnt == '0);

   // A cks rewrite restarts the divider so the next tick is a full period away.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)                presc <= 3'd0;
      else if (!run || cks_chg)  presc <= 3'd0;
      else if (tick)             presc <= 3'd0;
      else                       presc <= presc + 3'd1;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)     cnt <= '0;
      else if (load)  cnt <= tdr;
      else if (tick)  cnt <= dir ? cnt - 1'b1 : cnt + 1'b1;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tdr    <= '0;
         load   <= 1'b0;
         dir    <= 1'b0;
         en     <= 1'b0;
         cks    <= 2'd0;
         ovf_ie <= 1'b0;
         udf_ie <= 1'b0;
      end else if (wr) begin
         if (paddr == A_TDR) tdr <= pwdata;
         if (wr_tcr) begin
            load <= pwdata[7];
            dir  <= pwdata[5];
            en   <= pwdata[4];
            cks  <= pwdata[1:0];
         end
         if (paddr == A_TIER) begin
            ovf_ie <= pwdata[0];
            udf_ie <= pwdata[1];
         end
      end
   end

   // Set beats a same-cycle W1C clear.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         ovf <= ovf_set | (ovf & ~(wr_tsr & pwdata[0]));
         udf <= udf_set | (udf & ~(wr_tsr & pwdata[1]));
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) interrupt <= 1'b0;
      else        interrupt <= (ovf & ovf_ie) | (udf & udf_ie);
   end

   always_comb begin
      prdata = '0;
      if (rd && !preset) begin
         case (paddr)
            A_TDR:   prdata = tdr;
            A_TCR:   prdata = {load, 1'b0, dir, en, 2'b00, cks};
            A_TSR:   prdata = {6'b0, udf, ovf};
            A_TIER:  prdata = {6'b0, udf_ie, ovf_ie};
            A_TCNT:  prdata = cnt;
            default: prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer8.sv
// Scoreboarded bench for apb_timer8: each read pushes its expected value,
// which is popped and compared when the access phase presents prdata.
module tb_apb_timer8;

   logic       pclk = 1'b0;
   logic       preset = 1'b0;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic [7:0] prdata;
   logic       pready, interrupt;

   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];

   apb_timer8 #(.ADDR_W(8), .DATA_W(8)) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .interrupt(interrupt)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Tasks are entered and left on a falling edge; cyc counts rising edges.
   task automatic idle(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge pclk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d, output int commit);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      commit = cyc;
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
      logic [7:0] x;
      exp_q.push_back(e);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      x = exp_q.pop_front();
      chk(tag, prdata, x);
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
   endtask

   // Read whose access phase samples the state left by rising edge s.
   task automatic rd_at(input string tag, input logic [7:0] a, input logic [7:0] e, input int s);
      wait_until(s - 1);
      chk({tag, "_sched"}, cyc, s - 1);
      rd(tag, a, e);
   endtask

   function automatic logic [7:0] mdl(input logic [7:0] s, input bit dn, input int n, input int el);
      logic [7:0] t;
      t = 8'(el / n);
      return dn ? s - t : s + t;
   endfunction

   initial begin
      int c, w, s, x, d;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h04; pwdata = 8'h00;
      #1 preset = 1'b1;
      #2;
      chk("rst_prdata", prdata, 0);
      chk("rst_pready", pready, 0);
      chk("rst_irq", interrupt, 0);
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; preset = 1'b0;
      for (int a = 0; a < 5; a++) rd("rst_reg", 8'(a), 8'h00);
      wr(8'h07, 8'hAA, c);
      rd("rsvd_07", 8'h07, 8'h00);

      // count up /1
      wr(8'h00, 8'h10, c);
      wr(8'h01, 8'h80, c);
      wr(8'h01, 8'h10, w);
      rd_at("up1_early", 8'h04, mdl(8'h10, 0, 1, 3), w + 3);
      rd_at("up1_20", 8'h04, 8'h24, w + 20);
      rd("up1_tsr", 8'h02, 8'h00);
      wr(8'h01, 8'h00, s);
      rd_at("stop_hold", 8'h04, mdl(8'h10, 0, 1, s - w), s + 6);
      rd("tcr_rb0", 8'h01, 8'h00);

      // stop and load
      wr(8'h00, 8'h5A, c);
      wr(8'h01, 8'h80, c);
      rd("load_val", 8'h04, 8'h5A);
      rd("tcr_rb80", 8'h01, 8'h80);
      wr(8'h01, 8'h00, c);
      idle(4);
      rd("load_hold", 8'h04, 8'h5A);
      rd("load_noflag", 8'h02, 8'h00);

      // count up /4 through the wrap
      wr(8'h00, 8'hFC, c);
      wr(8'h01, 8'h80, c);
      wr(8'h03, 8'h01, c);
      rd("tier_rb", 8'h03, 8'h01);
      wr(8'h01, 8'h12, w);
      rd_at("up4_0", 8'h04, 8'hFC, w + 2);
      rd_at("up4_1", 8'h04, 8'hFD, w + 4);
      rd_at("up4_2", 8'h04, 8'hFE, w + 8);
      rd_at("up4_3", 8'h04, 8'hFF, w + 12);
      rd_at("up4_tsr0", 8'h02, 8'h00, w + 14);
      chk("up4_irq0", interrupt, 0);
      rd_at("up4_wrap", 8'h04, 8'h00, w + 16);
      chk("up4_irq1", interrupt, 1);
      rd_at("up4_tsr1", 8'h02, 8'h01, w + 18);
      wr(8'h01, 8'h02, c);
      wr(8'h02, 8'h01, c);
      chk("w1c_irq_lag", interrupt, 1);
      idle(1);
      chk("w1c_irq_drop", interrupt, 0);
      rd("w1c_tsr", 8'h02, 8'h00);

      // count down /8 through the wrap
      wr(8'h00, 8'h02, c);
      wr(8'h01, 8'h80, c);
      wr(8'h03, 8'h02, c);
      wr(8'h01, 8'h33, w);
      rd_at("dn8_0", 8'h04, 8'h02, w + 5);
      rd_at("dn8_1", 8'h04, 8'h01, w + 8);
      rd_at("dn8_2", 8'h04, 8'h00, w + 16);
      rd_at("dn8_edge", 8'h04, 8'h00, w + 23);
      chk("dn8_irq0", interrupt, 0);
      rd_at("dn8_wrap", 8'h04, 8'hFF, w + 25);
      chk("dn8_irq1", interrupt, 1);
      rd_at("dn8_tsr", 8'h02, 8'h02, w + 27);
      wr(8'h01, 8'h20, c);
      wr(8'h02, 8'h00, c);
      rd("w0_keep", 8'h02, 8'h02);
      chk("w0_irq", interrupt, 1);
      wr(8'h02, 8'h02, c);
      idle(1);
      chk("udf_clr_irq", interrupt, 0);
      rd("udf_clr_tsr", 8'h02, 8'h00);

      // cks /2 -> /8 mid-count
      wr(8'h00, 8'h40, c);
      wr(8'h01, 8'h80, c);
      wr(8'h01, 8'h11, w);
      wait_until(w + 5);
      wr(8'h01, 8'h13, x);
      chk("cks_commit", x, w + 7);
      rd_at("cks_pre", 8'h04, 8'h43, x + 6);
      rd_at("cks_tick", 8'h04, 8'h44, x + 8);

      // direction flip mid-count
      wait_until(x + 9);
      wr(8'h01, 8'h33, d);
      chk("dir_commit", d, x + 11);
      rd_at("dir_hold", 8'h04, 8'h44, x + 14);
      rd_at("dir_rev1", 8'h04, 8'h43, x + 16);
      rd_at("dir_rev2", 8'h04, 8'h42, x + 24);

      // asynchronous reset mid-count with the interrupt raised
      wr(8'h00, 8'h00, c);
      wr(8'h01, 8'hB0, c);
      wr(8'h01, 8'h30, w);
      idle(3);
      chk("pre_rst_irq", interrupt, 1);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h04;
      #2 preset = 1'b1;
      #1;
      chk("mid_rst_prdata", prdata, 0);
      chk("mid_rst_pready", pready, 0);
      chk("mid_rst_irq", interrupt, 0);
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; preset = 1'b0;
      for (int a = 0; a < 5; a++) rd("post_rst_reg", 8'(a), 8'h00);
      idle(5);
      rd("post_rst_idle", 8'h04, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/apb_timer8.md
Name: apb_timer8

Overview:
- 8-bit programmable up/down timer with an APB slave register interface and a level interrupt output.
- Software loads a start value, selects direction and a clock prescale (/1, /2, /4, /8), then enables counting.
- Overflow and underflow events set sticky status flags that can raise the interrupt.
- Sits on the peripheral APB bus; a single clock drives both the bus logic and the counter.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width and counter width (only 8 is supported)

Ports:
- pclk  in  1  single clock for the APB interface and the counter
- preset  in  1  reset, asynchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data
- pready  out  1  transfer complete
- interrupt  out  1  level interrupt

Behaviour:
- Register map (all unlisted bits read 0, writes to them ignored):
  - 0x00 TDR, RW: load value.
  - 0x01 TCR, RW: [7] load, [5] dir (0 = up, 1 = down), [4] en, [1:0] cks (00 = /1, 01 = /2, 10 = /4, 11 = /8).
  - 0x02 TSR, W1C: [0] ovf, [1] udf.
  - 0x03 TIER, RW: [0] ovf_ie, [1] udf_ie.
  - 0x04 TCNT, RO: current counter value.
  - 0x05–0xFF: reserved; read 0x00, writes have no effect.
- APB protocol:
  - Zero wait states: pready = psel & penable.
  - A write commits on the pclk rising edge where psel & penable & pwrite = 1.
  - Read: prdata is driven combinationally with the addressed register when psel & penable & !pwrite; otherwise prdata = 0x00.
  - Writes to TCNT are ignored.
- Reset (preset = 1, asynchronous): TDR, TCR, TSR, TIER, counter and prescaler all clear to 0; interrupt = 0; prdata = 0; pready = 0.
- Load:
  - While TCR.load = 1, the counter takes TDR on every clock and does not count, regardless of en.
  - The load bit stays set until software clears it.
- Prescaler:
  - A 3-bit counter that runs only when en = 1 and load = 0.
  - Generates tick every N clocks (N = 1, 2, 4 or 8); with N = 1, tick every clock.
  - Cleared to 0 when en = 0, when load = 1, or on any write that changes cks.
  - After a cks change, the first tick comes N clocks after the write.
- Counting:
  - On tick the counter changes by +1 (dir = 0) or −1 (dir = 1), modulo 256.
  - With en = 0 the counter holds its value.
  - A dir change mid-count continues from the current value in the new direction.
- Flags:
  - Up count 0xFF→0x00 sets TSR.ovf.
  - Down count 0x00→0xFF sets TSR.udf.
  - Loading a value never sets a flag.
  - Flags are sticky and cleared by writing 1 to the bit; writing 0 has no effect.
  - If a set event and a W1C clear occur in the same cycle, the set wins.
- interrupt: registered, equals (ovf & ovf_ie) | (udf & udf_ie); changes one clock after the flag or enable change.
- Reset mid-operation: everything returns immediately to reset values; counting resumes only after software reprograms TCR.

Test Plan:
- Reset values: after reset, read 0x00–0x04 → all 0x00; interrupt = 0; write then read 0x07 → 0x00.
- Count up, /1: TDR = 0x10, TCR = 0x80 then TCR = 0x10 → TCNT increments every clock; after 20 clocks TCNT = 0x24.
- Count up, /4: TDR = 0xFC, load, TCR = 0x12 → TCNT steps every 4 clocks: 0xFD, 0xFE, 0xFF, 0x00. TSR = 0x01 after the wrap; with TIER = 0x01, interrupt = 1 one clock later. Write TSR = 0x01 → TSR = 0x00 and interrupt drops.
- Count down, /8: TDR = 0x02, load, TCR = 0x33 → TCNT = 0x01, 0x00, 0xFF at 8-clock intervals; TSR = 0x02; with TIER = 0x02, interrupt = 1. Writing TSR = 0x00 leaves it set.
- Stop and load: with en = 0, TCNT holds. TCR = 0x80 with TDR = 0x5A → TCNT = 0x5A; clearing load keeps TCNT at 0x5A until en = 1.
- Mid-operation changes: switch cks from /2 to /8 while counting → next tick 8 clocks after the write. Flip dir during count → counting reverses from the current value. Assert preset mid-count → all registers 0x00 immediately.
